// File: rtl/cosim_commit_arbiter.sv
// cosim_commit_arbiter: per-core commit FIFOs serialised round-robin onto one Spike checker port
module cosim_commit_arbiter #(
  parameter int NUM_CORES = 1,
  parameter int DEPTH     = 8,
  parameter int XLEN      = 64,
  parameter int CID_W     = (NUM_CORES > 1 ? $clog2(NUM_CORES) : 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      setup_done,
  input  logic [NUM_CORES-1:0]      commit_valid,
  input  logic [NUM_CORES*XLEN-1:0] commit_pc,
  input  logic [NUM_CORES*32-1:0]   commit_insn,
  input  logic [NUM_CORES-1:0]      commit_rd_we,
  input  logic [NUM_CORES*5-1:0]    commit_rd,
  input  logic [NUM_CORES*XLEN-1:0] commit_wdata,
  output logic                      chk_valid,
  input  logic                      chk_ready,
  output logic [CID_W-1:0]          chk_core,
  output logic [XLEN-1:0]           chk_pc,
  output logic [31:0]               chk_insn,
  output logic                      chk_rd_we,
  output logic [4:0]                chk_rd,
  output logic [XLEN-1:0]           chk_wdata,
  output logic [31:0]               chk_seq,
  input  logic                      chk_mismatch,
  output logic [1:0]                state,
  output logic [NUM_CORES-1:0]      overflow,
  output logic [CID_W-1:0]          err_core,
  output logic [31:0]               err_seq,
  output logic [31:0]               checked_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * XLEN + 32 + 1 + 5 + 32;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [RW-1:0]        mem_q [NUM_CORES][DEPTH];
  logic [RW-1:0]        rec_in [NUM_CORES];
  logic [AW:0]          wr_q [NUM_CORES], wr_d [NUM_CORES];
  logic [AW:0]          rd_q [NUM_CORES], rd_d [NUM_CORES];
  logic [31:0]          seq_q [NUM_CORES], seq_d [NUM_CORES];
  logic [CID_W-1:0]     ptr_q, ptr_d, grant, err_core_q, err_core_d, drop_core;
  logic [NUM_CORES-1:0] ovf_q, ovf_d, nonempty, full, push, pop, drop;
  logic [31:0]          err_seq_q, err_seq_d, cnt_q, cnt_d, drop_seq;
  logic [RW-1:0]        head;
  logic                 hs;
  assign state       = state_q;
  assign overflow    = ovf_q;
  assign err_core    = err_core_q;
  assign err_seq     = err_seq_q;
  assign checked_cnt = cnt_q;
  assign chk_core    = grant;
  assign {chk_pc, chk_insn, chk_rd_we, chk_rd, chk_wdata, chk_seq} = head;
  // FIFO status and round-robin grant; ptr parks on a stalled grant so late arrivals cannot steal it
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      nonempty[c] = wr_q[c] != rd_q[c];
      full[c]     = wr_q[c] == {~rd_q[c][AW], rd_q[c][AW-1:0]};
      rec_in[c]   = {commit_pc[c*XLEN +: XLEN], commit_insn[c*32 +: 32], commit_rd_we[c],
                     commit_rd[c*5 +: 5], commit_wdata[c*XLEN +: XLEN], seq_q[c]};
    end
    grant = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (nonempty[(int'(ptr_q) + i) % NUM_CORES]) grant = CID_W'((int'(ptr_q) + i) % NUM_CORES);
    head      = mem_q[grant][rd_q[grant][AW-1:0]];
    chk_valid = (state_q == S_RUN) && |nonempty;
    hs        = chk_valid && chk_ready;
  end
  // next-state: push/pop/drop per core, sequence counters, error capture
  always_comb begin
    drop_core = '0;
    drop_seq  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      pop[c]   = hs && (grant == CID_W'(c));
      push[c]  = (state_q == S_RUN) && commit_valid[c] && (!full[c] || pop[c]);
      drop[c]  = (state_q == S_RUN) && commit_valid[c] && full[c] && !pop[c];
      wr_d[c]  = wr_q[c] + (AW+1)'(push[c]);
      rd_d[c]  = rd_q[c] + (AW+1)'(pop[c]);
      seq_d[c] = seq_q[c] + 32'((state_q == S_RUN) && commit_valid[c]);
    end
    for (int c = NUM_CORES - 1; c >= 0; c--)
      if (drop[c]) begin
        drop_core = CID_W'(c);
        drop_seq  = seq_q[c];
      end
    ovf_d      = ovf_q | drop;
    cnt_d      = cnt_q + 32'(hs);
    ptr_d      = hs ? CID_W'((int'(grant) + 1) % NUM_CORES) : chk_valid ? grant : ptr_q;
    state_d    = (state_q == S_IDLE && setup_done) ? S_RUN : state_q;
    err_core_d = err_core_q;
    err_seq_d  = err_seq_q;
    if (hs && chk_mismatch) begin
      state_d    = S_ERR;
      err_core_d = grant;
      err_seq_d  = chk_seq;
    end else if (|drop) begin
      state_d    = S_ERR;
      err_core_d = drop_core;
      err_seq_d  = drop_seq;
    end
  end
  // control and status flops, flushed immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      ovf_q      <= '0;
      err_core_q <= '0;
      err_seq_q  <= '0;
      cnt_q      <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        seq_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      err_core_q <= err_core_d;
      err_seq_q  <= err_seq_d;
      cnt_q      <= cnt_d;
      for (int c = 0; c < NUM_CORES; c++) begin
        wr_q[c]  <= wr_d[c];
        rd_q[c]  <= rd_d[c];
        seq_q[c] <= seq_d[c];
      end
    end
  end
  // FIFO storage; contents are meaningless outside the pointer window so no reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++)
      if (push[c]) mem_q[c][wr_q[c][AW-1:0]] <= rec_in[c];
  end
endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// tb_cosim_commit_arbiter: directed + randomized checks against a queue-based reference model
module tb_cosim_commit_arbiter;
  localparam int N = 4, D = 4, X = 64, CW = 2;
  logic            clk, rst_n, setup_done, chk_valid, chk_ready, chk_rd_we, chk_mismatch;
  logic [N-1:0]    commit_valid, commit_rd_we, overflow;
  logic [N*X-1:0]  commit_pc, commit_wdata;
  logic [N*32-1:0] commit_insn;
  logic [N*5-1:0]  commit_rd;
  logic [CW-1:0]   chk_core, err_core;
  logic [X-1:0]    chk_pc, chk_wdata;
  logic [31:0]     chk_insn, chk_seq, err_seq, checked_cnt;
  logic [4:0]      chk_rd;
  logic [1:0]      state;

  cosim_commit_arbiter #(.NUM_CORES(N), .DEPTH(D), .XLEN(X), .CID_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .setup_done(setup_done), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_insn(commit_insn), .commit_rd_we(commit_rd_we),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .chk_valid(chk_valid),
    .chk_ready(chk_ready), .chk_core(chk_core), .chk_pc(chk_pc), .chk_insn(chk_insn),
    .chk_rd_we(chk_rd_we), .chk_rd(chk_rd), .chk_wdata(chk_wdata), .chk_seq(chk_seq),
    .chk_mismatch(chk_mismatch), .state(state), .overflow(overflow), .err_core(err_core),
    .err_seq(err_seq), .checked_cnt(checked_cnt));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc; logic [31:0] insn; logic we; logic [4:0] rd; logic [63:0] wd; logic [31:0] seq;
  } rec_t;

  rec_t        q [N][$];
  int          mstate, mptr, mheld, merr_core, eg, checks, errors;
  logic [31:0] mseq [N];
  logic [31:0] merr_seq, mcnt;
  logic [N-1:0] movf;
  bit          ev;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      q[c].delete();
      mseq[c] = 0;
    end
    mstate = 0; mptr = 0; mheld = -1; movf = 0; merr_core = 0; merr_seq = 0; mcnt = 0;
  endfunction

  // which record the checker port should present: a stalled record stays, else next non-empty from ptr
  function automatic void predict();
    ev = 0; eg = 0;
    if (mstate == 1) begin
      if (mheld >= 0) begin
        ev = 1; eg = mheld;
      end else
        for (int i = 0; i < N; i++) begin
          int k = (mptr + i) % N;
          if (!ev && q[k].size() > 0) begin
            ev = 1; eg = k;
          end
        end
    end
  endfunction

  function automatic void update();
    rec_t r;
    int   fd;
    logic [31:0] dseq;
    bit   hs;
    if (!rst_n) begin
      model_reset();
      return;
    end
    predict();
    if (mstate == 0) begin
      if (setup_done) mstate = 1;
      return;
    end
    if (mstate == 2) return;
    hs = ev && chk_ready;
    r = '0;
    if (hs) begin
      r = q[eg].pop_front();
      mcnt++;
      mptr = (eg + 1) % N;
      mheld = -1;
    end else if (ev) mheld = eg;
    fd = -1; dseq = 0;
    for (int c = 0; c < N; c++)
      if (commit_valid[c]) begin
        if (q[c].size() < D)
          q[c].push_back({commit_pc[c*X +: X], commit_insn[c*32 +: 32], commit_rd_we[c],
                          commit_rd[c*5 +: 5], commit_wdata[c*X +: X], mseq[c]});
        else begin
          movf[c] = 1;
          if (fd < 0) begin
            fd = c; dseq = mseq[c];
          end
        end
        mseq[c]++;
      end
    if (hs && chk_mismatch) begin
      mstate = 2; merr_core = eg; merr_seq = r.seq;
    end else if (fd >= 0) begin
      mstate = 2; merr_core = fd; merr_seq = dseq;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    rec_t r;
    predict();
    chk("state", 64'(state), 64'(mstate));
    chk("chk_valid", 64'(chk_valid), 64'(ev));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("err_core", 64'(err_core), 64'(merr_core));
    chk("err_seq", 64'(err_seq), 64'(merr_seq));
    chk("checked_cnt", 64'(checked_cnt), 64'(mcnt));
    if (ev) begin
      r = q[eg][0];
      chk("chk_core", 64'(chk_core), 64'(eg));
      chk("chk_pc", chk_pc, r.pc);
      chk("chk_insn", 64'(chk_insn), 64'(r.insn));
      chk("chk_rd_we", 64'(chk_rd_we), 64'(r.we));
      chk("chk_rd", 64'(chk_rd), 64'(r.rd));
      chk("chk_wdata", chk_wdata, r.wd);
      chk("chk_seq", 64'(chk_seq), 64'(r.seq));
    end
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v);
    commit_valid = v;
    for (int c = 0; c < N; c++) begin
      commit_pc[c*X +: X]    = {$urandom, $urandom};
      commit_wdata[c*X +: X] = {$urandom, $urandom};
      commit_insn[c*32 +: 32] = $urandom;
      commit_rd[c*5 +: 5]    = 5'($urandom_range(31));
      commit_rd_we[c]        = 1'($urandom_range(1));
    end
  endtask

  initial begin
    logic [N-1:0] v;
    checks = 0; errors = 0;
    rst_n = 0; setup_done = 0; chk_ready = 0; chk_mismatch = 0;
    model_reset();
    drive(0);
    #1;
    repeat (3) cycle();
    rst_n = 1;
    // gating: commits before and on the setup_done edge are ignored
    repeat (5) begin drive(4'b0001); cycle(); end
    setup_done = 1; drive(4'b0001); cycle();
    setup_done = 0; drive(0); cycle();
    chk_ready = 1; drive(4'b0001); cycle();
    drive(0); repeat (2) cycle();
    chk("gate_cnt", 64'(checked_cnt), 64'd1);
    // round-robin: all cores push three times
    repeat (3) begin drive(4'hF); cycle(); end
    drive(0); repeat (14) cycle();
    chk("rr_cnt", 64'(checked_cnt), 64'd13);
    // backpressure: core1 record held while core0 arrives
    chk_ready = 0; drive(4'b0010); commit_pc[X +: X] = 64'h80000010; cycle();
    drive(0); cycle();
    drive(4'b0001); cycle();
    drive(0); repeat (3) cycle();
    chk("bp_core", 64'(chk_core), 64'd1);
    chk("bp_pc", chk_pc, 64'h80000010);
    chk_ready = 1; repeat (4) cycle();
    // random traffic kept below overflow
    repeat (300) begin
      v = '0;
      for (int c = 0; c < N; c++) if ($urandom_range(3) == 0 && q[c].size() < D - 1) v[c] = 1;
      drive(v);
      chk_ready = ($urandom_range(9) < 7);
      cycle();
    end
    drive(0); chk_ready = 1; repeat (12) cycle();
    // push + pop on a full FIFO is not an overflow
    chk_ready = 0; repeat (4) begin drive(4'b0100); cycle(); end
    chk_ready = 1; drive(4'b0100); cycle();
    drive(0); repeat (6) cycle();
    chk("full_ovf", 64'(overflow), 64'd0);
    chk("full_state", 64'(state), 64'd1);
    // mismatch on the fourth handshake, then frozen
    chk_ready = 0; repeat (4) begin drive(4'b0001); cycle(); end
    drive(0); chk_ready = 1; repeat (3) cycle();
    chk_mismatch = 1; cycle();
    chk_mismatch = 0;
    repeat (5) begin drive(4'b1111); cycle(); end
    chk("mm_state", 64'(state), 64'd2);
    chk("mm_core", 64'(err_core), 64'd0);
    // asynchronous reset with records queued
    rst_n = 0; drive(0); #1; model_reset(); cycle();
    rst_n = 1; setup_done = 1; cycle();
    setup_done = 0; chk_ready = 0; drive(4'b0111); cycle();
    drive(0); cycle();
    rst_n = 0; #1; model_reset(); check_outputs();
    cycle();
    rst_n = 1; setup_done = 1; cycle();
    // double overflow: cores 1 and 3 push five times into depth-4 FIFOs
    setup_done = 0;
    repeat (5) begin drive(4'b1010); cycle(); end
    drive(0); repeat (3) cycle();
    chk("ovf_bits", 64'(overflow), 64'b1010);
    chk("ovf_core", 64'(err_core), 64'd1);
    chk("ovf_seq", 64'(err_seq), 64'd4);
    chk("ovf_valid", 64'(chk_valid), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
